// File: rtl/pc_fetch_unit_pkg.sv
// Shared encodings for the PIC16C5x fetch/PC stage.
// Fetch Q-states, execute states, stack commands, NOP/PCL constants.
package pc_fetch_unit_pkg;

  localparam int FE_STATE_BITS = 2;
  localparam int EX_STATE_BITS = 4;

  typedef enum logic [FE_STATE_BITS-1:0] {
    FE_Q1 = 2'd0,
    FE_Q2 = 2'd1,
    FE_Q3 = 2'd2,
    FE_Q4 = 2'd3
  } fe_state_e;

  typedef enum logic [EX_STATE_BITS-1:0] {
    EX_Q1       = 4'd0,
    EX_Q2       = 4'd1,
    EX_Q3       = 4'd2,
    EX_Q4       = 4'd3,
    EX_Q4_GOTO  = 4'd4,
    EX_Q4_CALL  = 4'd5,
    EX_Q4_RETLW = 4'd6,
    EX_Q4_FSZ   = 4'd7,
    EX_Q4_BTFSX = 4'd8
  } ex_state_e;

  typedef enum logic [1:0] {
    STK_NOP  = 2'd0,
    STK_PUSH = 2'd1,
    STK_POP  = 2'd2
  } stk_cmd_e;

  localparam logic [11:0] INST_NOP = 12'h000;
  localparam logic [4:0]  PCL_ADDR = 5'h02;

  // Page bits on top of a 9-bit in-page address.
  function automatic logic [10:0] page_addr(
    input logic [1:0] pg,
    input logic [8:0] lo
  );
    return {pg, lo};
  endfunction

endpackage

// File: rtl/pc_fetch_unit_hw_stack.sv
// Two-level return stack: push shifts down, pop duplicates stk1.
// Ports: clk, rst_n, i_push, i_pop, i_data, o_top (+diag flags under PC_STACK_DIAG_EN).
module hw_stack #(
  parameter int PC_WIDTH = 11
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_push,
  input  logic                i_pop,
  input  logic [PC_WIDTH-1:0] i_data,
  output logic [PC_WIDTH-1:0] o_top
`ifdef PC_STACK_DIAG_EN
  ,
  output logic                o_overflow,
  output logic                o_underflow
`endif
);

  logic [PC_WIDTH-1:0] r_stk0;
  logic [PC_WIDTH-1:0] r_stk1;

  assign o_top = r_stk0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stk0 <= '0;
      r_stk1 <= '0;
    end else if (i_push) begin
      r_stk1 <= r_stk0;
      r_stk0 <= i_data;
    end else if (i_pop) begin
      r_stk0 <= r_stk1;
    end
  end

`ifdef PC_STACK_DIAG_EN
  // Depth saturates at 0..2; the flags are sticky until reset.
  logic [1:0] r_depth;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_depth     <= 2'd0;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else if (i_push) begin
      if (r_depth == 2'd2) o_overflow <= 1'b1;
      else                 r_depth    <= r_depth + 2'd1;
    end else if (i_pop) begin
      if (r_depth == 2'd0) o_underflow <= 1'b1;
      else                 r_depth     <= r_depth - 2'd1;
    end
  end
`endif

endmodule

// File: rtl/pc_fetch_unit.sv
// PIC16C5x fetch stage: PC, 2-level stack and IR; redirects on FE_Q4.
// Optional PC_STACK_DIAG_EN adds stkOverflow/stkUnderflow outputs.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int PC_WIDTH   = 11,
  parameter int INST_WIDTH = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [FE_STATE_BITS-1:0] fetchState,
  input  logic [EX_STATE_BITS-1:0] executeState,
  input  logic [1:0]               stackCommand,
  input  logic                     skipCond,
  input  logic [1:0]               pageSel,
  input  logic                     pclWe,
  input  logic [7:0]               pclData,
  input  logic [INST_WIDTH-1:0]    romData,
  output logic [PC_WIDTH-1:0]      romAddr,
  output logic [INST_WIDTH-1:0]    instOut,
  output logic [PC_WIDTH-1:0]      pcOut
`ifdef PC_STACK_DIAG_EN
  ,
  output logic                     stkOverflow,
  output logic                     stkUnderflow
`endif
);

  logic [PC_WIDTH-1:0]   r_pc;
  logic [INST_WIDTH-1:0] r_ir;

  logic                w_q4;
  logic                w_push;
  logic                w_pop;
  logic                w_skip;
  logic                w_redirect;
  logic [PC_WIDTH-1:0] w_pc_inc;
  logic [PC_WIDTH-1:0] w_pc_nxt;
  logic [PC_WIDTH-1:0] w_stk0;
  logic [10:0]         w_goto;
  logic [10:0]         w_call;
  logic [10:0]         w_pcl;

  assign w_q4     = (fetchState == FE_Q4);
  assign w_push   = w_q4 && (stackCommand == STK_PUSH);
  assign w_pop    = w_q4 && (stackCommand == STK_POP);
  assign w_pc_inc = r_pc + 1'b1;
  assign w_skip   = skipCond &&
                    ((executeState == EX_Q4_FSZ) ||
                     (executeState == EX_Q4_BTFSX));

  // CALL and PCL writes force bit 8 low.
  assign w_goto = page_addr(pageSel, r_ir[8:0]);
  assign w_call = page_addr(pageSel, {1'b0, r_ir[7:0]});
  assign w_pcl  = page_addr(pageSel, {1'b0, pclData});

  always_comb begin
    w_redirect = 1'b1;
    w_pc_nxt   = w_pc_inc;
    if (executeState == EX_Q4_GOTO) begin
      w_pc_nxt = w_goto[PC_WIDTH-1:0];
    end else if (executeState == EX_Q4_CALL) begin
      w_pc_nxt = w_call[PC_WIDTH-1:0];
    end else if (executeState == EX_Q4_RETLW) begin
      w_pc_nxt = w_stk0;
    end else if (pclWe) begin
      w_pc_nxt = w_pcl[PC_WIDTH-1:0];
    end else if (!w_skip) begin
      w_redirect = 1'b0;
    end
  end

  // A redirect discards the word on romData by loading a NOP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= '1;
      r_ir <= INST_WIDTH'(INST_NOP);
    end else if (w_q4) begin
      r_pc <= w_pc_nxt;
      r_ir <= w_redirect ? INST_WIDTH'(INST_NOP) : romData;
    end
  end

  hw_stack #(
    .PC_WIDTH (PC_WIDTH)
  ) u_stack (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_data      (r_pc),
    .o_top       (w_stk0)
`ifdef PC_STACK_DIAG_EN
    ,
    .o_overflow  (stkOverflow),
    .o_underflow (stkUnderflow)
`endif
  );

  assign romAddr = r_pc;
  assign pcOut   = r_pc;
  assign instOut = r_ir;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomized bench for pc_fetch_unit against an instruction-cycle model.
// Checks PC, IR and (with PC_STACK_DIAG_EN) the stack diag flags.
module tb_pc_fetch_unit;
  import pc_fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  fetchState;
  logic [3:0]  executeState;
  logic [1:0]  stackCommand;
  logic        skipCond;
  logic [1:0]  pageSel;
  logic        pclWe;
  logic [7:0]  pclData;
  logic [11:0] romData;
  logic [10:0] romAddr;
  logic [11:0] instOut;
  logic [10:0] pcOut;
`ifdef PC_STACK_DIAG_EN
  logic        stkOverflow;
  logic        stkUnderflow;
`endif

  logic [11:0] rom [0:2047];

  int n_chk  = 0;
  int n_fail = 0;

  int          m_pc;
  logic [11:0] m_ir;
  int          m_stk [2];
  int          m_depth;
  bit          m_ovf;
  bit          m_unf;

  always #5 clk = ~clk;

  assign romData = rom[romAddr];

  pc_fetch_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fetchState   (fetchState),
    .executeState (executeState),
    .stackCommand (stackCommand),
    .skipCond     (skipCond),
    .pageSel      (pageSel),
    .pclWe        (pclWe),
    .pclData      (pclData),
    .romData      (romData),
    .romAddr      (romAddr),
    .instOut      (instOut),
    .pcOut        (pcOut)
`ifdef PC_STACK_DIAG_EN
    ,
    .stkOverflow  (stkOverflow),
    .stkUnderflow (stkUnderflow)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_pc"}, 32'(pcOut), 32'(m_pc));
    chk({tag, "_addr"}, 32'(romAddr), 32'(m_pc));
    chk({tag, "_ir"}, 32'(instOut), 32'(m_ir));
`ifdef PC_STACK_DIAG_EN
    chk({tag, "_ovf"}, 32'(stkOverflow), 32'(m_ovf));
    chk({tag, "_unf"}, 32'(stkUnderflow), 32'(m_unf));
`endif
  endtask

  task automatic model_reset();
    m_pc    = 'h7FF;
    m_ir    = 12'h000;
    m_stk   = '{0, 0};
    m_depth = 0;
    m_ovf   = 0;
    m_unf   = 0;
  endtask

  // One instruction cycle's Q4 edge, in ISA terms.
  task automatic model_q4(input logic [3:0] ex, input logic [1:0] stk,
                          input logic sk, input logic [1:0] pg,
                          input logic we, input logic [7:0] d);
    int  npc;
    bit  redir;
    int  old_pc;
    old_pc = m_pc;
    redir  = 1;
    if (ex == EX_Q4_GOTO)
      npc = pg * 512 + (m_ir % 512);
    else if (ex == EX_Q4_CALL)
      npc = pg * 512 + (m_ir % 256);
    else if (ex == EX_Q4_RETLW)
      npc = m_stk[0];
    else if (we)
      npc = pg * 512 + d;
    else begin
      npc   = (m_pc + 1) % 2048;
      redir = sk && (ex == EX_Q4_FSZ || ex == EX_Q4_BTFSX);
    end
    m_ir = redir ? 12'h000 : rom[m_pc];
    m_pc = npc;
    if (stk == STK_PUSH) begin
      m_stk[1] = m_stk[0];
      m_stk[0] = old_pc;
      if (m_depth == 2) m_ovf = 1;
      else m_depth++;
    end else if (stk == STK_POP) begin
      m_stk[0] = m_stk[1];
      if (m_depth == 0) m_unf = 1;
      else m_depth--;
    end
  endtask

  // Q1..Q3 carry random junk that must be ignored; Q4 carries the args.
  task automatic instr(input logic [3:0] ex, input logic [1:0] stk,
                       input logic sk, input logic [1:0] pg,
                       input logic we, input logic [7:0] d);
    for (int q = 0; q < 3; q++) begin
      @(negedge clk);
      fetchState   = 2'(q);
      executeState = 4'($urandom_range(0, 8));
      stackCommand = 2'($urandom_range(0, 3));
      skipCond     = 1'($urandom);
      pageSel      = 2'($urandom);
      pclWe        = 1'($urandom);
      pclData      = 8'($urandom);
      @(posedge clk);
      #1;
      check_state("hold");
    end
    @(negedge clk);
    fetchState   = FE_Q4;
    executeState = ex;
    stackCommand = stk;
    skipCond     = sk;
    pageSel      = pg;
    pclWe        = we;
    pclData      = d;
    @(posedge clk);
    model_q4(ex, stk, sk, pg, we, d);
    #1;
    check_state("q4");
  endtask

  task automatic plain();
    instr(EX_Q4, STK_NOP, 1'b0, 2'b00, 1'b0, 8'h00);
  endtask

  logic [3:0] ex_tab [6];

  initial begin
    for (int i = 0; i < 2048; i++) rom[i] = 12'(i);
    rom[11'h000] = 12'hB23;
    rom[11'h010] = 12'h945;
    ex_tab = '{EX_Q4, EX_Q4_GOTO, EX_Q4_CALL,
               EX_Q4_RETLW, EX_Q4_FSZ, EX_Q4_BTFSX};

    rst_n        = 1'b0;
    fetchState   = FE_Q1;
    executeState = EX_Q1;
    stackCommand = STK_NOP;
    skipCond     = 1'b0;
    pageSel      = 2'b00;
    pclWe        = 1'b0;
    pclData      = 8'h00;
    model_reset();
    repeat (2) @(negedge clk);
    check_state("reset");
    rst_n = 1'b1;

    plain();
    chk("first_ir", 32'(instOut), 32'h7FF);
    chk("wrap_pc", 32'(romAddr), 32'h000);
    plain();
    instr(EX_Q4_GOTO, STK_NOP, 1'b0, 2'b01, 1'b0, 8'h00);
    chk("goto_pc", 32'(pcOut), 32'h323);
    chk("goto_nop", 32'(instOut), 32'h000);
    plain();
    chk("goto_fetch", 32'(instOut), 32'h323);
    instr(EX_Q4, STK_NOP, 1'b0, 2'b10, 1'b1, 8'h80);
    chk("pcl_pc", 32'(pcOut), 32'h480);
    chk("pcl_nop", 32'(instOut), 32'h000);
    instr(EX_Q4, STK_NOP, 1'b0, 2'b00, 1'b1, 8'h10);
    plain();
    instr(EX_Q4_CALL, STK_PUSH, 1'b0, 2'b00, 1'b0, 8'h00);
    chk("call_pc", 32'(pcOut), 32'h045);
    plain();
    instr(EX_Q4_RETLW, STK_POP, 1'b0, 2'b00, 1'b0, 8'h00);
    chk("ret_pc", 32'(pcOut), 32'h011);
    chk("ret_nop", 32'(instOut), 32'h000);
    instr(EX_Q4, STK_NOP, 1'b0, 2'b00, 1'b1, 8'h20);
    plain();
    instr(EX_Q4_FSZ, STK_NOP, 1'b1, 2'b00, 1'b0, 8'h00);
    chk("skip_pc", 32'(pcOut), 32'h022);
    chk("skip_nop", 32'(instOut), 32'h000);
    instr(EX_Q4_BTFSX, STK_NOP, 1'b0, 2'b00, 1'b0, 8'h00);
    chk("noskip_ir", 32'(instOut), 32'h022);

    for (int k = 0; k < 3; k++) begin
      instr(EX_Q4_CALL, STK_PUSH, 1'b0, 2'(k), 1'b0, 8'h00);
      plain();
    end
    for (int k = 0; k < 3; k++) begin
      instr(EX_Q4_RETLW, STK_POP, 1'b0, 2'b00, 1'b0, 8'h00);
      plain();
    end
`ifdef PC_STACK_DIAG_EN
    chk("diag_ovf", 32'(stkOverflow), 32'd1);
    chk("diag_unf", 32'(stkUnderflow), 32'd1);
`endif

    @(negedge clk);
    fetchState = FE_Q2;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_state("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    instr(EX_Q4_RETLW, STK_POP, 1'b0, 2'b00, 1'b0, 8'h00);
    chk("rst_stk", 32'(pcOut), 32'h000);

    for (int n = 0; n < 400; n++) begin
      logic [3:0] ex;
      logic [1:0] stk;
      ex  = ex_tab[$urandom_range(0, 5)];
      stk = (ex == EX_Q4_CALL)  ? STK_PUSH :
            (ex == EX_Q4_RETLW) ? STK_POP  : STK_NOP;
      if ($urandom_range(0, 9) == 0) stk = 2'($urandom);
      instr(ex, stk, 1'($urandom), 2'($urandom),
            ($urandom_range(0, 3) == 0), 8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Instruction-fetch and program-counter stage for the PIC16C5x core; sits directly upstream of ControlUnit and drives its instIn.
- Owns the PC, the 2-level hardware stack and the instruction register (IR).
- Consumes ControlUnit's fetchState, executeState and stackCommand to perform sequential fetch, GOTO/CALL/RETLW, PCL writes and skip flushes.

Parameters:
- PC_WIDTH, 11, program counter / ROM address width (2K words; 9 for 16C54).
- INST_WIDTH, 12, instruction width (matches `INST_WIDTH).

Ports:
- clk  input  1  core clock (one edge per Q-state)
- rst_n  input  1  asynchronous reset, active low
- fetchState  input  `FE_STATE_BITS  current fetch Q-state from ControlUnit
- executeState  input  `EX_STATE_BITS  current execute state from ControlUnit
- stackCommand  input  2  `STK_PUSH / `STK_POP / `STK_NOP
- skipCond  input  1  ALU zero (FSZ) or bit-test result (BTFSX) requesting a skip
- pageSel  input  2  STATUS PA1:PA0, supplies PC bits above bit 8
- pclWe  input  1  register-file write to PCL this Q4
- pclData  input  8  data written to PCL
- romData  input  INST_WIDTH  program ROM read data
- romAddr  output  PC_WIDTH  program ROM address (= pc)
- instOut  output  INST_WIDTH  instruction register, to ControlUnit instIn
- pcOut  output  PC_WIDTH  current PC, for PCL reads

Behaviour:
- Async reset: pc = all ones (reset vector 0x7FF at default width), instOut = 12'h000 (NOP), stack entries = 0.
- romAddr is combinational from pc; the ROM is sampled only on the FE_Q4 edge.
- FE_Q1..FE_Q3: pc, IR and stack hold.
- FE_Q4 edge with no redirect: IR <= romData; pc <= pc+1, wrapping modulo 2^PC_WIDTH.
- Fetch and execute are phase-aligned (ControlUnit resets both to Q3). The instruction fetched in cycle n executes in cycle n+1.
- Redirects are evaluated on the same Q4 edge. Priority, highest first:
  1. executeState == EX_Q4_GOTO: pc <= {pageSel, inst[8:0]} (pageSel[1] only when PC_WIDTH=11).
  2. EX_Q4_CALL: push pc (the return address, already pointing past CALL); pc <= {pageSel, 1'b0, inst[7:0]}.
  3. EX_Q4_RETLW: pc <= stk0; pop.
  4. pclWe: pc <= {pageSel, 1'b0, pclData}.
  5. (EX_Q4_FSZ or EX_Q4_BTFSX) and skipCond: pc <= pc+1.
- Any redirect loads IR with NOP (12'h000) instead of romData. Effect: 2-cycle branch/skip; the discarded instruction executes as NOP.
- inst above means the current IR value (the instruction now in execute).
- Stack:
  - Push: stk1 <= stk0, stk0 <= value. A third push silently drops the old stk1.
  - Pop: stk0 <= stk1; stk1 unchanged. Underflow returns the duplicated value.
  - stackCommand is acted on only when fetchState == FE_Q4; otherwise ignored.
- pclWe and skipCond outside FE_Q4 are ignored.
- Reset mid-cycle: reset takes effect immediately; no partial update survives.

Optional Feature:
- Macro: PC_STACK_DIAG_EN.
- Defined: adds outputs stkOverflow and stkUnderflow (1 bit each), reset 0.
  - stkOverflow sets sticky on a push with depth already 2.
  - stkUnderflow sets sticky on a pop with depth 0.
  - Internal 2-bit depth counter saturates at 0..2.
- Undefined: no depth counter and no extra ports; functional behaviour is identical.

Decomposition:
- define.v gains: `RESET_VECTOR, `INST_NOP (12'h000), `PCL_ADDR (5'h02).
- define.v reuses the existing `FE_*, `EX_*, `STK_* encodings.
- Sub-module hw_stack (2-level, PC_WIDTH parameter): push/pop/top, plus the diag counters under PC_STACK_DIAG_EN.

Test Plan:
- Reset, ROM returns incrementing data: romAddr=0x7FF; after first FE_Q4, instOut=romData@0x7FF and romAddr wraps to 0x000.
- IR=GOTO 0x123 (0xB23), pageSel=2'b01, at EX_Q4_GOTO: pc=0x323, instOut=0x000 for one cycle, then romData@0x323.
- CALL 0x45 at 0x010, then RETLW in the callee: stk0=0x011; after RETLW, pc=0x011 and one NOP is inserted.
- Three nested CALLs then three RETLWs: return to 3rd then 2nd caller, third RETLW repeats the 2nd address. With PC_STACK_DIAG_EN: stkOverflow=1, stkUnderflow=1.
- DECFSZ with skipCond=1 at pc=0x020 (IR fetched 0x020): pc=0x022, instOut=0x000. With skipCond=0: normal fetch.
- pclWe=1, pclData=0x80, pageSel=2'b10 at FE_Q4: pc=0x480, IR=NOP. pclWe pulsed at FE_Q2: no effect.
